// File: rtl/aes_decrypt_byteserial_pkg.sv
// Shared AES-128 constants, FSM encoding, S-box tables and GF(2^8)/key-schedule helpers
// used by the byte-serial decryptor.
package aes_pkg;

    localparam int NR       = 10;
    localparam int NB_BYTES = 16;
    localparam int BYTE_W   = 8;

    typedef logic [BYTE_W-1:0]          aes_byte_t;
    typedef logic [NB_BYTES*BYTE_W-1:0] aes_block_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_EXPAND = 3'd2,
        ST_ROUND  = 3'd3,
        ST_OUTPUT = 3'd4
    } aes_fsm_e;

    localparam aes_byte_t SBOX_TBL [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam aes_byte_t INV_SBOX_TBL [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic aes_byte_t sbox(input aes_byte_t x);
        return SBOX_TBL[x];
    endfunction

    function automatic aes_byte_t inv_sbox(input aes_byte_t x);
        return INV_SBOX_TBL[x];
    endfunction

    // Round constants for key-schedule steps 1..10.
    function automatic aes_byte_t rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic aes_byte_t xtime(input aes_byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_byte_t gmul9(input aes_byte_t a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic aes_byte_t gmul11(input aes_byte_t a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic aes_byte_t gmul13(input aes_byte_t a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic aes_byte_t gmul14(input aes_byte_t a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    function automatic aes_block_t key_expand_step(input aes_block_t rk, input aes_byte_t rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = rk[127:96];
        w1 = rk[95:64];
        w2 = rk[63:32];
        w3 = rk[31:0];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_decrypt_byteserial_inv_round.sv
// One AES inverse-cipher round, purely combinational: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] next_state
);

    aes_byte_t sub_b [NB_BYTES];
    aes_byte_t ark_b [NB_BYTES];
    aes_byte_t a0, a1, a2, a3;

    always_comb begin
        sub_b = '{default: '0};
        ark_b = '{default: '0};
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        next_state = '0;
        // Byte k = row + 4*col; row r of column c comes from column (c - r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_b[4*c + r] = inv_sbox(state[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
            end
        end
        for (int k = 0; k < NB_BYTES; k++) begin
            ark_b[k] = sub_b[k] ^ round_key[127 - 8*k -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            a0 = ark_b[4*c];
            a1 = ark_b[4*c + 1];
            a2 = ark_b[4*c + 2];
            a3 = ark_b[4*c + 3];
            if (last_round) begin
                next_state[127 - 32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                next_state[127 - 32*c -: 32] = {
                    gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                    gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                    gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                    gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)
                };
            end
        end
    end

endmodule

// File: rtl/aes_decrypt_byteserial.sv
// Byte-serial AES-128 decryptor: loads key/ciphertext, expands 11 round keys, runs one inverse
// round per cycle, streams plaintext out. Optional AES_DEC_KEY_CACHE_EN skips expansion on key reuse.
module aes_decrypt_byteserial
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] key_byte,
    input  logic [7:0] state_byte,
    output logic       load,
    output logic       ready,
    output logic [7:0] state_out_byte
);

    localparam logic [3:0] LAST_RND  = 4'(NR);
    localparam logic [3:0] LAST_BYTE = 4'(NB_BYTES - 1);

    aes_fsm_e   state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] rnd_q, rnd_d;
    logic       ready_q, ready_d;
    aes_byte_t  out_q, out_d;

    logic [119:0] key_sh_q;
    aes_block_t   ct_q;
    aes_block_t   s_q;
    aes_block_t   rk_q [0:NR];
    aes_block_t   key_full;
    aes_block_t   inv_next;
    logic         key_hit;

    assign key_full = {key_sh_q, key_byte};

`ifdef AES_DEC_KEY_CACHE_EN
    logic key_valid_q;

    // rk_q[0] doubles as the cached key; it only changes at the end of a LOAD.
    assign key_hit = key_valid_q && (key_full == rk_q[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid_q <= 1'b0;
        end else if (enable && state_q == ST_EXPAND && rnd_q == LAST_RND) begin
            key_valid_q <= 1'b1;
        end
    end
`else
    assign key_hit = 1'b0;
`endif

    aes_inv_round u_inv_round (
        .state      (s_q),
        .round_key  (rk_q[LAST_RND - rnd_q]),
        .last_round (rnd_q == LAST_RND),
        .next_state (inv_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rnd_q   <= '0;
            ready_q <= 1'b0;
            out_q   <= '0;
        end else if (enable) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            ready_q <= ready_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        ready_d = ready_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
            ST_LOAD: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_BYTE) begin
                    cnt_d = '0;
                    if (key_hit) begin
                        state_d = ST_ROUND;
                        rnd_d   = '0;
                    end else begin
                        state_d = ST_EXPAND;
                        rnd_d   = 4'd1;
                    end
                end
            end
            ST_EXPAND: begin
                if (rnd_q == LAST_RND) begin
                    state_d = ST_ROUND;
                    rnd_d   = '0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            ST_ROUND: begin
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) begin
                    state_d = ST_OUTPUT;
                    ready_d = 1'b1;
                    out_d   = inv_next[127:120];
                    cnt_d   = '0;
                end
            end
            ST_OUTPUT: begin
                if (cnt_q == LAST_BYTE) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    out_d = s_q[119:112];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        load = (state_q == ST_LOAD);
    end

    assign ready          = ready_q;
    assign state_out_byte = out_q;

    // Datapath registers carry no reset; the control path decides when they are meaningful.
    always_ff @(posedge clk) begin
        if (enable) begin
            case (state_q)
                ST_LOAD: begin
                    key_sh_q <= {key_sh_q[111:0], key_byte};
                    ct_q     <= {ct_q[119:0], state_byte};
                    if (cnt_q == LAST_BYTE) begin
                        rk_q[0] <= key_full;
                    end
                end
                ST_EXPAND: begin
                    rk_q[rnd_q] <= key_expand_step(rk_q[rnd_q - 4'd1], rcon(rnd_q));
                end
                ST_ROUND: begin
                    if (rnd_q == 4'd0) begin
                        s_q <= ct_q ^ rk_q[LAST_RND];
                    end else begin
                        s_q <= inv_next;
                    end
                end
                ST_OUTPUT: begin
                    s_q <= {s_q[119:0], 8'h00};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_byteserial.sv
// Self-checking bench for aes_decrypt_byteserial: known-answer table, enable toggling,
// mid-block reset, and random blocks produced by a behavioural AES-128 encryptor model.
module tb_aes_decrypt_byteserial;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] key_byte;
    logic [7:0] state_byte;
    logic       load;
    logic       ready;
    logic [7:0] state_out_byte;

    always #5 clk = ~clk;

    aes_decrypt_byteserial dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .key_byte       (key_byte),
        .state_byte     (state_byte),
        .load           (load),
        .ready          (ready),
        .state_out_byte (state_out_byte)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] cache_key;
    bit           cache_vld;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           pen;
    } vec_t;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox_m[t[23:16]] ^ rc, sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 16; k++) st[k] = pt[127 - 8*k -: 8] ^ w[k/4][31 - 8*(k%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    tmp[r + 4*c] = sbox_m[st[r + 4*((c + r) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    st[4*c]   = gm(tmp[4*c], 2) ^ gm(tmp[4*c+1], 3) ^ tmp[4*c+2] ^ tmp[4*c+3];
                    st[4*c+1] = tmp[4*c] ^ gm(tmp[4*c+1], 2) ^ gm(tmp[4*c+2], 3) ^ tmp[4*c+3];
                    st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ gm(tmp[4*c+2], 2) ^ gm(tmp[4*c+3], 3);
                    st[4*c+3] = gm(tmp[4*c], 3) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ gm(tmp[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) st[4*c+r] = tmp[4*c+r];
                end
            end
            for (int k = 0; k < 16; k++) st[k] = st[k] ^ w[4*rnd + k/4][31 - 8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) res[127 - 8*k -: 8] = st[k];
        return res;
    endfunction

    function automatic int exp_lat(input logic [127:0] key);
`ifdef AES_DEC_KEY_CACHE_EN
        return (cache_vld && key == cache_key) ? 11 : 21;
`else
        return (key === 'x) ? 0 : 21;
`endif
    endfunction

    function automatic bit pick_en(input int pen);
        return int'($urandom_range(99)) < pen;
    endfunction

    task automatic load_phase(input logic [127:0] key, input logic [127:0] ct, input int pen, input string nm);
        int idx, guard;
        bit en, ld;
        idx   = 0;
        guard = 0;
        while (idx < 16 && guard < 400) begin
            en         = pick_en(pen);
            enable     = en;
            key_byte   = key[127 - 8*idx -: 8];
            state_byte = ct[127 - 8*idx -: 8];
            ld         = load;
            tick();
            if (ld && en) idx++;
            guard++;
        end
        if (idx < 16) chk({nm, "_load_timeout"}, 128'(idx), 128'(16));
    endtask

    task automatic finish_phase(input logic [127:0] exp_pt, input int lat_exp, input int pen, input string nm);
        int lat, nb, guard;
        bit en;
        logic [7:0]   prev;
        logic [127:0] got;
        lat   = 0;
        guard = 0;
        while (!ready && guard < 400) begin
            en     = pick_en(pen);
            enable = en;
            tick();
            if (en) lat++;
            guard++;
        end
        chk({nm, "_latency"}, 128'(lat), 128'(lat_exp));
        got  = '0;
        nb   = 0;
        prev = state_out_byte;
        if (ready) begin
            got[127:120] = state_out_byte;
            nb = 1;
        end
        while (ready && guard < 800) begin
            en     = pick_en(pen);
            enable = en;
            tick();
            guard++;
            if (!en) begin
                chk({nm, "_hold"}, 128'({ready, state_out_byte}), 128'({1'b1, prev}));
            end else if (ready) begin
                if (nb < 16) got[127 - 8*nb -: 8] = state_out_byte;
                prev = state_out_byte;
                nb++;
            end
        end
        chk({nm, "_nbytes"}, 128'(nb), 128'(16));
        chk({nm, "_plaintext"}, got, exp_pt);
        chk({nm, "_tail"}, 128'({ready, state_out_byte}), 128'({1'b0, prev}));
    endtask

    task automatic run_block(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt,
                             input int pen, input string nm);
        int l;
        l = exp_lat(key);
        load_phase(key, ct, pen, nm);
        finish_phase(pt, l, pen, nm);
        cache_vld = 1'b1;
        cache_key = key;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [5];
        logic [127:0] rkey, rpt, rct, prev_key;
        int           l;

        rst        = 1'b1;
        enable     = 1'b0;
        key_byte   = 8'h00;
        state_byte = 8'h00;
        cache_vld  = 1'b0;
        cache_key  = '0;
        build_sbox();

        tbl[0] = '{K1, C1, P1, 100};
        tbl[1] = '{K2, C2, P2, 100};
        tbl[2] = '{K2, C2, P2, 50};
        tbl[3] = '{K2, C2, P2, 100};
        tbl[4] = '{K1, C1, P1, 70};

        @(negedge clk);
        tick();
        tick();
        chk("reset_load", 128'(load), 128'(0));
        chk("reset_ready", 128'(ready), 128'(0));
        chk("reset_out", 128'(state_out_byte), 128'(0));
        rst = 1'b0;
        enable = 1'b0;
        tick();
        tick();
        chk("idle_hold_load", 128'(load), 128'(0));

        for (int i = 0; i < 5; i++) begin
            run_block(tbl[i].key, tbl[i].ct, tbl[i].pt, tbl[i].pen, $sformatf("vec%0d", i));
        end

        // Finish with vector 2 so state_out_byte is nonzero before the abort.
        run_block(K2, C2, P2, 100, "pre_abort");
        l = exp_lat(K1);
        load_phase(K1, C1, 100, "abort");
        enable = 1'b1;
        for (int i = 0; i < l - 5; i++) tick();
        chk("abort_mid_ready", 128'(ready), 128'(0));
        rst = 1'b1;
        tick();
        chk("abort_load", 128'(load), 128'(0));
        chk("abort_ready", 128'(ready), 128'(0));
        chk("abort_out", 128'(state_out_byte), 128'(0));
        rst = 1'b0;
        cache_vld = 1'b0;
        run_block(K1, C1, P1, 100, "after_abort");

        prev_key = K1;
        for (int i = 0; i < 100; i++) begin
            rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (i % 10 == 9) rkey = prev_key;
            rpt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rct  = ref_encrypt(rkey, rpt);
            run_block(rkey, rct, rpt, 60 + int'($urandom_range(40)), $sformatf("rand%0d", i));
            prev_key = rkey;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
